// File: rtl/register7_pkg.sv
// Shared types and constants for the register_7 storage stage of the SDM datapath.
package register7_pkg;

    localparam int REG7_WIDTH = 7;

    typedef logic [REG7_WIDTH-1:0] reg7_word_t;

    localparam reg7_word_t REG7_RESET_VALUE = '0;

endpackage

// File: rtl/dff_ar_n.sv
// Single-bit D flip-flop with asynchronous active-low reset and a per-bit reset value.
module dff_ar_n #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic data_d;
    logic data_q;

    always_comb begin
        data_d = d;
    end

    // Reset is asynchronous so the stored bit is forced even with no clock running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/register_7.sv
// 7-bit PIPO storage register built from per-bit async-reset flops.
// Define REGISTER7_PARITY_EN to add a registered even-parity output q_parity.
module register_7
    import register7_pkg::*;
#(
    parameter int                 WIDTH       = REG7_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef REGISTER7_PARITY_EN
    ,
    output logic             q_parity
`endif
);

    // Each bit carries its own reset value so any RESET_VALUE pattern is honoured.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_ar_n #(
            .RESET_VAL (RESET_VALUE[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .d     (d[i]),
            .q     (q[i])
        );
    end

`ifdef REGISTER7_PARITY_EN
    logic parity_d;

    // Parity is computed from d and registered so it stays aligned with q.
    always_comb begin
        parity_d = ^d;
    end

    dff_ar_n #(
        .RESET_VAL (^RESET_VALUE)
    ) u_parity (
        .clk   (clk),
        .reset (reset),
        .d     (parity_d),
        .q     (q_parity)
    );
`endif

endmodule

// File: tb/tb_register_7.sv
// Scoreboard bench for register_7; parity checks run when REGISTER7_PARITY_EN is defined.
module tb_register_7;
    import register7_pkg::*;

    logic       clk;
    logic       reset;
    reg7_word_t d;
    reg7_word_t q;
`ifdef REGISTER7_PARITY_EN
    logic       q_parity;
`endif

    int errors = 0;
    int checks = 0;

    reg7_word_t exp_q[$];
    reg7_word_t exp_val;

    register_7 dut (
        .clk      (clk),
        .reset    (reset),
        .d        (d),
        .q        (q)
`ifdef REGISTER7_PARITY_EN
        ,
        .q_parity (q_parity)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic pop_and_compare(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, q=%h", name, q);
        end else begin
            exp_val = exp_q.pop_front();
            if (q !== exp_val) begin
                errors++;
                $display("[TB] FAIL %s: q=%h expected=%h", name, q, exp_val);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            #5;
            checks++;
            if (q !== 7'h00) begin
                errors++;
                $display("[TB] FAIL reset_hold[%0d]: q=%h expected=00", i, q);
            end
            @(posedge clk);
            #1;
            checks++;
            if (q !== 7'h00) begin
                errors++;
                $display("[TB] FAIL reset_edge[%0d]: q=%h expected=00", i, q);
            end
        end
    endtask

    task automatic test_release();
        @(negedge clk);
        reset = 1'b1;
        d     = 7'b0101010;
        #1;
        checks++;
        if (q !== 7'h00) begin
            errors++;
            $display("[TB] FAIL release_pre_edge: q=%h expected=00", q);
        end
        exp_q.push_back(7'b0101010);
        @(posedge clk);
        #1;
        pop_and_compare("release_first_capture");
    endtask

    task automatic test_pipeline();
        reg7_word_t vals[4] = '{7'h7F, 7'h00, 7'h55, 7'h2A};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = vals[i];
            exp_q.push_back(vals[i]);
            @(posedge clk);
            #1;
            pop_and_compare("pipeline");
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        d = 7'h7F;
        exp_q.push_back(7'h7F);
        @(posedge clk);
        #1;
        pop_and_compare("async_preload");
        @(negedge clk);
        #5;
        reset = 1'b0;
        #1;
        checks++;
        if (q !== 7'h00) begin
            errors++;
            $display("[TB] FAIL async_immediate: q=%h expected=00", q);
        end
        d = 7'h33;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (q !== 7'h00) begin
                errors++;
                $display("[TB] FAIL async_hold[%0d]: q=%h expected=00", i, q);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(7'h33);
        @(posedge clk);
        #1;
        pop_and_compare("async_release");
    endtask

    task automatic test_hold();
        @(negedge clk);
        d = 7'h11;
        exp_q.push_back(7'h11);
        @(posedge clk);
        #1;
        pop_and_compare("hold_load");
        #3;
        d = 7'h22;
        #2;
        checks++;
        if (q !== 7'h11) begin
            errors++;
            $display("[TB] FAIL hold_clk_high: q=%h expected=11", q);
        end
        @(negedge clk);
        #1;
        checks++;
        if (q !== 7'h11) begin
            errors++;
            $display("[TB] FAIL hold_falling_edge: q=%h expected=11", q);
        end
        #3;
        d = 7'h44;
        #2;
        checks++;
        if (q !== 7'h11) begin
            errors++;
            $display("[TB] FAIL hold_clk_low: q=%h expected=11", q);
        end
        exp_q.push_back(7'h44);
        @(posedge clk);
        #1;
        pop_and_compare("hold_next_edge");
    endtask

    task automatic test_back_to_back();
        reg7_word_t v;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v = reg7_word_t'($urandom_range(0, 127));
            d = v;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            pop_and_compare("back_to_back");
        end
    endtask

`ifdef REGISTER7_PARITY_EN
    task automatic test_parity();
        reg7_word_t vals[2] = '{7'b0101010, 7'b0000011};
        logic       exp_par[2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d = vals[i];
            @(posedge clk);
            #1;
            checks++;
            if (q_parity !== exp_par[i]) begin
                errors++;
                $display("[TB] FAIL parity[%0d]: q_parity=%b expected=%b", i, q_parity, exp_par[i]);
            end
        end
        @(negedge clk);
        d = 7'b0000111;
        @(posedge clk);
        #5;
        reset = 1'b0;
        #1;
        checks++;
        if (q_parity !== 1'b0) begin
            errors++;
            $display("[TB] FAIL parity_reset: q_parity=%b expected=0", q_parity);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask
`endif

    initial begin
        reset = 1'b0;
        d     = 7'b0101010;
        test_reset();
        test_release();
        test_pipeline();
        test_async_reset();
        test_hold();
        test_back_to_back();
`ifdef REGISTER7_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
